// File: rtl/freq_ratio_win.sv
// -----------------------------------------------------------------------------
// freq_ratio_win
//
// Continuously running frequency-ratio meter for the ADPLL loop. A free-running
// Gray-coded counter in the ring-oscillator domain (F_ring) is sampled in the
// reference domain (F_clk). The number of ring edges seen over a programmable
// window of reference cycles is reported as an unsigned ratio word. Windows run
// back to back with no dead cycles.
//
// Optional feature (compile-time macro FREQ_LOCK_DET_EN):
//   adds parameters LOCK_TOL / LOCK_CNT and output "lock", asserted after
//   LOCK_CNT consecutive windows whose ratio stays within LOCK_TOL of the
//   previous window.
//
// Ports:
//   F_clk      in   reference clock; all outputs are in this domain
//   combReset  in   asynchronous, active-high reset (both domains)
//   F_ring     in   ring-oscillator clock
//   En         in   measurement enable (F_clk domain)
//   win_len    in   window length in F_clk cycles; 0 selects WIN_DEFAULT
//   C_freq     out  ring edges counted in the last completed window
//   C_valid    out  one-cycle strobe: C_freq updated
//   C_ovf      out  last window saturated C_freq
//   busy       out  window in progress
//   lock       out  (FREQ_LOCK_DET_EN only) ratio is stable
// -----------------------------------------------------------------------------
module freq_ratio_win #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned RING_W      = 24,
   parameter int unsigned WIN_W       = 16,
   parameter int unsigned WIN_DEFAULT = 100,
   parameter int unsigned SYNC_STAGES = 2
`ifdef FREQ_LOCK_DET_EN
   ,
   parameter int unsigned LOCK_TOL    = 2,
   parameter int unsigned LOCK_CNT    = 4
`endif
) (
   input  logic             F_clk,
   input  logic             combReset,
   input  logic             F_ring,
   input  logic             En,
   input  logic [WIN_W-1:0] win_len,
   output logic [CNT_W-1:0] C_freq,
   output logic             C_valid,
   output logic             C_ovf,
   output logic             busy
`ifdef FREQ_LOCK_DET_EN
   ,
   output logic             lock
`endif
);

   // Widest of the ring and result words, used for the saturation compare.
   localparam int unsigned MAX_W  = (RING_W > CNT_W) ? RING_W : CNT_W;
   localparam int unsigned INIT_W = $clog2(SYNC_STAGES + 2);
   localparam logic [INIT_W-1:0] InitLast = INIT_W'(SYNC_STAGES + 1);

   // --------------------------------------------------------------------------
   // Ring domain
   // --------------------------------------------------------------------------
   logic [1:0]        ringRstSync;
   logic              ringRst;
   logic [RING_W-1:0] ringBin;
   logic [RING_W-1:0] ringGray;

   // Reset assertion is asynchronous; release is re-timed onto F_ring.
   always_ff @(posedge F_ring or posedge combReset) begin
      if (combReset) begin
         ringRstSync <= 2'b11;
      end else begin
         ringRstSync <= {ringRstSync[0], 1'b0};
      end
   end

   assign ringRst = ringRstSync[1];

   always_ff @(posedge F_ring or posedge combReset) begin
      if (combReset) begin
         ringBin  <= '0;
         ringGray <= '0;
      end else if (ringRst) begin
         ringBin  <= '0;
         ringGray <= '0;
      end else begin
         ringBin  <= ringBin + RING_W'(1);
         // Registered Gray copy: the only signal that crosses into F_clk.
         ringGray <= ringBin ^ (ringBin >> 1);
      end
   end

   // --------------------------------------------------------------------------
   // Gray synchroniser into F_clk and conversion back to binary
   // --------------------------------------------------------------------------
   logic [RING_W-1:0] graySync [SYNC_STAGES];
   logic [RING_W-1:0] syncBin;

   always_ff @(posedge F_clk or posedge combReset) begin
      if (combReset) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            graySync[i] <= '0;
         end
      end else begin
         graySync[0] <= ringGray;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            graySync[i] <= graySync[i-1];
         end
      end
   end

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      syncBin = '0;
      for (int i = 0; i < int'(RING_W); i++) begin
         syncBin[i] = ^(graySync[SYNC_STAGES-1] >> i);
      end
   end

   // --------------------------------------------------------------------------
   // Window control
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      StInit,
      StIdle,
      StMeasure
   } state_e;

   state_e            state;
   logic [INIT_W-1:0] initCnt;
   logic [WIN_W-1:0]  winL;
   logic [WIN_W-1:0]  cnt;
   logic [RING_W-1:0] start;

   logic [WIN_W-1:0]  winSel;
   logic [RING_W-1:0] delta;
   logic [MAX_W-1:0]  deltaExt;
   logic [CNT_W-1:0]  satLimit;
   logic              sat;
   logic [CNT_W-1:0]  newFreq;
   logic              armEdge;
   logic              winDone;

   always_comb begin
      winSel   = (win_len == '0) ? WIN_W'(WIN_DEFAULT) : win_len;
      // Modular difference: transparent to ring counter wrap.
      delta    = syncBin - start;
      deltaExt = MAX_W'(delta);
      satLimit = '1;
      sat      = (deltaExt > MAX_W'(satLimit));
      newFreq  = sat ? satLimit : CNT_W'(deltaExt);
      armEdge  = (state == StIdle) && En;
      winDone  = (state == StMeasure) && En && (cnt == winL);
   end

   always_ff @(posedge F_clk or posedge combReset) begin
      if (combReset) begin
         state   <= StInit;
         initCnt <= '0;
         winL    <= '0;
         cnt     <= '0;
         start   <= '0;
         C_freq  <= '0;
         C_valid <= 1'b0;
         C_ovf   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         C_valid <= 1'b0;
         unique case (state)
            // Let the synchroniser flush stale samples before the first window.
            StInit: begin
               if (initCnt == InitLast) begin
                  state <= StIdle;
               end else begin
                  initCnt <= initCnt + INIT_W'(1);
               end
            end
            StIdle: begin
               if (En) begin
                  winL  <= winSel;
                  start <= syncBin;
                  cnt   <= WIN_W'(1);
                  state <= StMeasure;
                  busy  <= 1'b1;
               end
            end
            StMeasure: begin
               if (!En) begin
                  // Abort: results of the partial window are discarded.
                  state <= StIdle;
                  busy  <= 1'b0;
               end else if (cnt == winL) begin
                  // Window boundary: next window starts on this same edge.
                  start   <= syncBin;
                  cnt     <= WIN_W'(1);
                  winL    <= winSel;
                  C_valid <= 1'b1;
                  C_freq  <= newFreq;
                  C_ovf   <= sat;
               end else begin
                  cnt <= cnt + WIN_W'(1);
               end
            end
            default: begin
               state   <= StInit;
               initCnt <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef FREQ_LOCK_DET_EN
   // --------------------------------------------------------------------------
   // Lock detection
   // --------------------------------------------------------------------------
   localparam int unsigned DIFF_W = CNT_W + 1;
   localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);

   logic [CNT_W-1:0]  prevFreq;
   logic              seeded;
   logic [RUN_W-1:0]  runCnt;
   logic [DIFF_W-1:0] diffRaw;
   logic [DIFF_W-1:0] absDiff;
   logic              inTol;

   always_comb begin
      diffRaw = {1'b0, newFreq} - {1'b0, prevFreq};
      absDiff = diffRaw[DIFF_W-1] ? (DIFF_W'(0) - diffRaw) : diffRaw;
      // A saturated window never counts as in tolerance.
      inTol   = !sat && (absDiff <= DIFF_W'(LOCK_TOL));
   end

   always_ff @(posedge F_clk or posedge combReset) begin
      if (combReset) begin
         prevFreq <= '0;
         seeded   <= 1'b0;
         runCnt   <= '0;
         lock     <= 1'b0;
      end else if (!En) begin
         seeded <= 1'b0;
         runCnt <= '0;
         lock   <= 1'b0;
      end else if (armEdge) begin
         seeded <= 1'b0;
         runCnt <= '0;
      end else if (winDone) begin
         prevFreq <= newFreq;
         seeded   <= 1'b1;
         // The first window after arming only provides the reference value.
         if (seeded) begin
            if (inTol) begin
               if (runCnt != RUN_W'(LOCK_CNT)) begin
                  runCnt <= runCnt + RUN_W'(1);
               end
               if (runCnt >= RUN_W'(LOCK_CNT - 1)) begin
                  lock <= 1'b1;
               end
            end else begin
               runCnt <= '0;
               lock   <= 1'b0;
            end
         end
      end
   end
`endif

endmodule
